// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bus between the core array and the data-memory arbiter
//   read_MD/write_MD  per-core level requests, held until ack
//   ar_in             per-core 16-bit word address, core k = [16k+15:16k]
//   dmem_in           per-core write data, core k = [DW*k+DW-1:DW*k]
//   dmem_out          shared registered read data
//   ack               one-hot, one-cycle completion pulse
//   busy              arbiter is not idle
interface dmem_arbiter_if #(
  parameter int NUM_CORES  = 4,
  parameter int DATA_WIDTH = 16
);
  logic [NUM_CORES-1:0]            read_MD;
  logic [NUM_CORES-1:0]            write_MD;
  logic [NUM_CORES*16-1:0]         ar_in;
  logic [NUM_CORES*DATA_WIDTH-1:0] dmem_in;
  logic [DATA_WIDTH-1:0]           dmem_out;
  logic [NUM_CORES-1:0]            ack;
  logic                            busy;
  modport master (output read_MD, write_MD, ar_in, dmem_in, input dmem_out, ack, busy);
  modport slave  (input read_MD, write_MD, ar_in, dmem_in, output dmem_out, ack, busy);
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin responder owning a single-port data RAM, one access per 3 cycles
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    dmem_arbiter_if slave side (requests, address/data in, dmem_out, ack, busy)
module dmem_arbiter #(
  parameter int NUM_CORES  = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  localparam int GW = $clog2(NUM_CORES);
  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;
  state_t                state, state_nx;
  logic [NUM_CORES-1:0]  req;
  logic [GW-1:0]         last_grant, grant, pick, cand;
  logic                  found, op_wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata, dout;
  logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];
  assign req = bus.read_MD | bus.write_MD;
  // scan from the farthest offset down so the nearest requester after last_grant wins
  always_comb begin
    pick  = last_grant;
    cand  = '0;
    found = 1'b0;
    for (int i = NUM_CORES; i >= 1; i--) begin
      cand = GW'((int'(last_grant) + i) % NUM_CORES);
      if (req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state == IDLE ? (found ? ACCESS : IDLE) : state == ACCESS ? RESPOND : IDLE;
  end
  always_comb begin
    bus.busy     = state != IDLE;
    bus.ack      = state == RESPOND ? NUM_CORES'(1) << grant : '0;
    bus.dmem_out = dout;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= GW'(NUM_CORES - 1);
      grant      <= '0;
      op_wr      <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      dout       <= '0;
    end else if (state == IDLE && found) begin
      last_grant <= pick;
      grant      <= pick;
      op_wr      <= bus.write_MD[pick];
      addr       <= bus.ar_in[int'(pick)*16 +: ADDR_WIDTH];
      wdata      <= bus.dmem_in[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
    end else if (state == ACCESS && !op_wr) begin
      dout <= ram[addr];
    end
  end
  // RAM has no reset; an async reset during ACCESS forces IDLE before the edge, so no write lands
  always_ff @(posedge clk) begin
    if (state == ACCESS && op_wr) ram[addr] <= wdata;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random checks of dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;
  localparam int N = 4, AW = 12, DW = 16;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  dmem_arbiter_if #(.NUM_CORES(N), .DATA_WIDTH(DW)) bus();
  dmem_arbiter #(.NUM_CORES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  int checks = 0, errors = 0;
  bit [N-1:0] rd = '0, wr = '0, sticky = '0;
  logic [15:0] ad [N];
  logic [DW-1:0] dt [N];
  logic [DW-1:0] mem_m [1<<AW];
  logic [DW-1:0] exp_dout = '0;
  logic [N-1:0] exp_ack;
  int edge_n = 0, idle_from = 0, ack_edge = -1, mlast = N - 1;
  int pg = 0;
  bit pw = 0;
  logic [AW-1:0] pa;
  logic [DW-1:0] pd;
  int grants[$];
  int dut_ack_at [N];
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drive();
    for (int k = 0; k < N; k++) begin
      bus.read_MD[k] = rd[k];
      bus.write_MD[k] = wr[k];
      bus.ar_in[16*k +: 16] = ad[k];
      bus.dmem_in[DW*k +: DW] = dt[k];
    end
  endtask
  task automatic req(int k, bit r, bit w, logic [15:0] a, logic [DW-1:0] d);
    rd[k] = r; wr[k] = w; ad[k] = a; dt[k] = d;
  endtask
  // one clock: model decides the grant from the current requests, then outputs are compared
  task automatic cycle();
    int g = -1;
    int cur = edge_n;
    drive();
    if (edge_n >= idle_from)
      for (int i = 1; i <= N; i++) begin
        int k = (mlast + i) % N;
        if (g < 0 && (rd[k] || wr[k])) g = k;
      end
    if (g >= 0) begin
      pg = g; pw = wr[g]; pa = ad[g][AW-1:0]; pd = dt[g];
      ack_edge = cur + 1; idle_from = cur + 3; mlast = g;
      grants.push_back(g);
    end
    @(posedge clk); #1;
    exp_ack = '0;
    if (cur == ack_edge) begin
      exp_ack[pg] = 1'b1;
      if (pw) mem_m[pa] = pd;
      else exp_dout = mem_m[pa];
    end
    chk("ack", 32'(bus.ack), 32'(exp_ack));
    chk("busy", 32'(bus.busy), 32'(ack_edge >= 0 && cur >= ack_edge - 1 && cur <= ack_edge));
    chk("dmem_out", 32'(bus.dmem_out), 32'(exp_dout));
    for (int k = 0; k < N; k++) begin
      if (bus.ack[k]) dut_ack_at[k] = cur;
      if (exp_ack[k] && !sticky[k]) begin rd[k] = 1'b0; wr[k] = 1'b0; end
    end
    edge_n++;
  endtask
  task automatic run(int maxc);
    int n = 0;
    while (((|rd) || (|wr) || edge_n < idle_from) && n < maxc) begin cycle(); n++; end
    chk("run_timeout", 32'(n < maxc), 32'd1);
  endtask
  // asserted #1 after an edge, i.e. mid-cycle; outputs must clear without waiting for the clock
  task automatic do_reset();
    reset = 1'b1;
    rd = '0; wr = '0; sticky = '0;
    drive();
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_dout", 32'(bus.dmem_out), 32'd0);
    ack_edge = -1; mlast = N - 1; exp_dout = '0;
    @(posedge clk); #1;
    edge_n++;
    reset = 1'b0;
    idle_from = edge_n;
  endtask
  initial begin
    int s;
    for (int k = 0; k < N; k++) begin ad[k] = '0; dt[k] = '0; dut_ack_at[k] = -1; end
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("init_busy", 32'(bus.busy), 32'd0);
    chk("init_ack", 32'(bus.ack), 32'd0);
    chk("init_dout", 32'(bus.dmem_out), 32'd0);
    reset = 1'b0;
    // test 1: write then read through core 0, ack one edge after the grant edge
    s = edge_n;
    req(0, 0, 1, 16'h0010, 16'h00A5); run(20);
    chk("t1_wr_lat", 32'(dut_ack_at[0] - s), 32'd1);
    for (int a = 0; a < 16; a++) begin req(a % N, 0, 1, 16'(a), 16'($urandom)); run(20); end
    req(1, 0, 1, 16'h0030, 16'h3333); run(20);
    s = edge_n;
    req(0, 1, 0, 16'h0010, 16'h0); run(20);
    chk("t1_rd_lat", 32'(dut_ack_at[0] - s), 32'd1);
    chk("t1_rd_data", 32'(bus.dmem_out), 32'h00A5);
    // test 2: all cores read together from a fresh reset
    do_reset();
    grants.delete();
    s = edge_n;
    for (int k = 0; k < N; k++) req(k, 1, 0, 16'(k + 1), 16'h0);
    run(40);
    chk("t2_ngrants", 32'(grants.size()), 32'(N));
    for (int k = 0; k < N; k++) chk("t2_order", 32'(grants[k]), 32'(k));
    chk("t2_first", 32'(dut_ack_at[0] - s), 32'd1);
    for (int k = 1; k < N; k++) chk("t2_spacing", 32'(dut_ack_at[k] - dut_ack_at[k-1]), 32'd3);
    // test 3: core 2 continuous, core 1 once
    grants.delete();
    sticky[2] = 1'b1; req(2, 1, 0, 16'h0005, 16'h0);
    cycle();
    req(1, 1, 0, 16'h0006, 16'h0);
    repeat (12) cycle();
    sticky[2] = 1'b0; rd[2] = 1'b0;
    run(20);
    chk("t3_g0", 32'(grants[0]), 32'd2);
    chk("t3_g1", 32'(grants[1]), 32'd1);
    chk("t3_g2", 32'(grants[2]), 32'd2);
    chk("t3_g3", 32'(grants[3]), 32'd2);
    // test 4: read and write together means write
    req(1, 1, 1, 16'h0020, 16'h1234); run(20);
    req(2, 1, 0, 16'h0020, 16'h0); run(20);
    chk("t4_rw_is_write", 32'(bus.dmem_out), 32'h1234);
    // test 5: upper address bits ignored
    req(3, 1, 0, 16'hF010, 16'h0); run(20);
    chk("t5_alias_rd", 32'(bus.dmem_out), 32'h00A5);
    req(3, 0, 1, 16'hF010, 16'h7777); run(20);
    req(0, 1, 0, 16'h0010, 16'h0); run(20);
    chk("t5_alias_wr", 32'(bus.dmem_out), 32'h7777);
    // test 6: reset during a write's ACCESS cycle discards it
    req(0, 0, 1, 16'h0030, 16'hBEEF);
    cycle();
    chk("t6_in_access", 32'(bus.busy), 32'd1);
    do_reset();
    req(2, 1, 0, 16'h0030, 16'h0); run(20);
    chk("t6_old_value", 32'(bus.dmem_out), 32'h3333);
    // early drop after grant still completes
    req(1, 1, 0, 16'h0003, 16'h0);
    cycle();
    rd[1] = 1'b0;
    dut_ack_at[1] = -1;
    run(20);
    chk("early_drop_ack", 32'(dut_ack_at[1] >= 0), 32'd1);
    // random traffic over pre-written low addresses with junk in the ignored upper bits
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!rd[k] && !wr[k] && $urandom_range(2) == 0) begin
          int r = $urandom_range(2);
          req(k, r != 1, r != 0, {4'($urandom), 8'h00, 4'($urandom)}, DW'($urandom));
        end else if ((rd[k] || wr[k]) && $urandom_range(15) == 0) begin
          rd[k] = 1'b0; wr[k] = 1'b0;
        end
      end
      cycle();
    end
    rd = '0; wr = '0;
    run(20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
